// File: rtl/atpg_pkg.sv
// rtl/atpg_pkg.sv - shared state type and default parameters for ATPG test-mode entry
// Contents:
//   ATPG_KEY_W / ATPG_KEY : unlock key length and value (shifted MSB first)
//   ATPG_DGL_N            : consecutive equal samples needed to accept a TST level change
//   ATPG_TMO_N            : idle cycles after which a partially received key is discarded
//   atpg_state_e          : entry FSM states
package atpg_pkg;

  localparam int                    ATPG_KEY_W = 16;
  localparam logic [ATPG_KEY_W-1:0] ATPG_KEY   = 16'hC127;
  localparam int                    ATPG_DGL_N = 3;
  localparam int                    ATPG_TMO_N = 255;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    TEST,
    LOCK
  } atpg_state_e;

endpackage

// File: rtl/sync_dgl.sv
// rtl/sync_dgl.sv - two-flop pad synchroniser with optional N-sample deglitch filter
// Ports:
//   clk  : core clock
//   srst : synchronous active-high reset, clears both sync flops and the filter
//   d_i  : asynchronous pad level
//   q_o  : synchronised level; with DGL_N > 0 it moves only after DGL_N
//          consecutive synchronised samples that differ from the current output
module sync_dgl #(
  parameter int DGL_N = 3
) (
  input  logic clk,
  input  logic srst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  if (DGL_N == 0) begin : g_plain
    assign q_o = s2_q;
  end else begin : g_dgl
    localparam int CW = $clog2(DGL_N + 1);

    logic [CW-1:0] cnt_q;
    logic          lvl_q;

    // cnt_q counts the run of samples disagreeing with lvl_q; any agreeing
    // sample restarts the run, so short pulses never reach the output.
    always_ff @(posedge clk) begin
      if (srst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DGL_N - 1)) begin
        cnt_q <= '0;
        lvl_q <= s2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign q_o = lvl_q;
  end

endmodule

// File: rtl/atpg_entry_ctrl.sv
// rtl/atpg_entry_ctrl.sv - ATPG test-mode entry: TST qualification, serial unlock key, scan-enable gating
// Ports:
//   clk         : core clock, the only clock
//   srst        : synchronous active-high reset
//   tst_i       : TST pad level (asynchronous), deglitched before use
//   scl_i       : SCL pad level (asynchronous), rising edge shifts one key bit
//   sda_i       : SDA pad level (asynchronous), key data sampled on SCL rise
//   se_i        : GPIO1 raw scan-enable request
//   scan_mode_o : registered, core is in ATPG mode
//   scan_en_o   : scan_mode_o AND se_i, combinational so shift timing is untouched
//   key_err_o   : registered, wrong key received and lockout active
//   arm_o       : registered, TST qualified and key reception in progress
module atpg_entry_ctrl
  import atpg_pkg::*;
#(
  parameter int               KEY_W = ATPG_KEY_W,
  parameter logic [KEY_W-1:0] KEY   = KEY_W'(ATPG_KEY),
  parameter int               DGL_N = ATPG_DGL_N,
  parameter int               TMO_N = ATPG_TMO_N
) (
  input  logic clk,
  input  logic srst,
  input  logic tst_i,
  input  logic scl_i,
  input  logic sda_i,
  input  logic se_i,
  output logic scan_mode_o,
  output logic scan_en_o,
  output logic key_err_o,
  output logic arm_o
);

  localparam int BCW = $clog2(KEY_W + 1);
  localparam int TCW = $clog2(TMO_N + 1);

  logic tst_q;
  logic scl_s;
  logic sda_s;
  logic scl_rise;

  logic             scl_prev_q;
  atpg_state_e      state_q, state_d;
  logic [KEY_W-1:0] sr_q, sr_d, sr_shift;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic             scan_mode_q, key_err_q, arm_q;

  sync_dgl #(.DGL_N(DGL_N)) u_tst (.clk(clk), .srst(srst), .d_i(tst_i), .q_o(tst_q));
  sync_dgl #(.DGL_N(0))     u_scl (.clk(clk), .srst(srst), .d_i(scl_i), .q_o(scl_s));
  sync_dgl #(.DGL_N(0))     u_sda (.clk(clk), .srst(srst), .d_i(sda_i), .q_o(sda_s));

  assign scl_rise = scl_s & ~scl_prev_q;
  assign sr_shift = {sr_q[KEY_W-2:0], sda_s};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (tst_q) begin
          state_d = ARM;
          sr_d    = '0;
          bcnt_d  = '0;
          tmo_d   = '0;
        end
      end
      ARM: begin
        // Priority: TST loss beats a completing key bit; a key bit beats the timeout.
        if (!tst_q) begin
          state_d = IDLE;
        end else if (scl_rise) begin
          sr_d   = sr_shift;
          bcnt_d = bcnt_q + 1'b1;
          tmo_d  = '0;
          if (bcnt_q == BCW'(KEY_W - 1)) begin
            state_d = (sr_shift == KEY) ? TEST : LOCK;
          end
        end else if (bcnt_q != '0) begin
          if (tmo_q != TCW'(TMO_N)) begin
            tmo_d = tmo_q + 1'b1;
          end
          // Counter is about to reach TMO_N: drop the partial key, stay armed.
          if (tmo_q == TCW'(TMO_N - 1)) begin
            sr_d   = '0;
            bcnt_d = '0;
          end
        end
      end
      TEST, LOCK: begin
        if (!tst_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bcnt_q      <= '0;
      tmo_q       <= '0;
      scl_prev_q  <= 1'b0;
      scan_mode_q <= 1'b0;
      key_err_q   <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      tmo_q       <= tmo_d;
      scl_prev_q  <= scl_s;
      scan_mode_q <= (state_d == TEST);
      key_err_q   <= (state_d == LOCK);
      arm_q       <= (state_d == ARM);
    end
  end

  assign scan_mode_o = scan_mode_q;
  assign scan_en_o   = scan_mode_q & se_i;
  assign key_err_o   = key_err_q;
  assign arm_o       = arm_q;

endmodule
